// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All line-facing outputs come straight from flops; the next-state logic only feeds them.
`timescale 1ns/1ps

module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          stop_q, stop_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          bit_end_s;
  logic          stop_last_s;

  function automatic logic par_bit(input logic [7:0] b);
    logic p;
    if (PARITY == 1) begin
      p = ~^b;
    end else begin
      p = ^b;
    end
    return p;
  endfunction

  assign bit_end_s   = (cnt_q == CNT_LAST);
  // stop_q marks the second stop bit; only STOP_BITS of 1 or 2 are meaningful
  assign stop_last_s = (STOP_BITS == 2) ? stop_q : 1'b1;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: frame sequencing and bit timing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    stop_d  = stop_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end_s ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          shreg_d = data;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (bit_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (stop_last_s) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered line lines up with the state
  always_comb begin
    txd_d   = 1'b1;
    done_d  = 1'b0;
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[idx_d];
      S_PAR:   txd_d = par_bit(shreg_d);
      default: txd_d = 1'b1;
    endcase
    if ((state_q == S_STOP) && (state_d == S_IDLE)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  assign ready = ready_q;
  assign txd   = txd_q;
  assign done  = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises one byte per request onto txd. It is the stage directly upstream of uart_rx: its txd drives uart_rx.rxd in loopback benches and on the board. Framing is 1 start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. The defaults match uart_rx: 50 MHz clk, 115200 baud, 434 clocks per bit (8680 ns).

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD, integer truncation (434 at defaults)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2; other values are illegal

Ports:
clk    input   1  system clock, rising edge
rst    input   1  synchronous reset, active-high
start  input   1  transmit request; sampled only while ready=1
data   input   8  byte to send; captured on the accepting edge
ready  output  1  1 = IDLE, request can be accepted
txd    output  1  serial line, idles high
done   output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; ready=1, txd=1, done=0; baud counter, bit index and shift register cleared. The same applies mid-frame: txd returns high on the next edge, no done pulse, and the partial frame is abandoned.
- Acceptance: start=1 and ready=1 at a rising edge. On that edge data is latched into the shift register and the state moves to START. From the next cycle, ready=0 and txd=0.
- Input handling during a frame: start while ready=0 is ignored, not queued. Changes on data after acceptance have no effect.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- Bit timing: each state/bit holds txd for exactly BAUD_DIV cycles, counted by a baud counter 0..BAUD_DIV-1. The counter wraps to 0 on each bit boundary.
- START: txd=0.
- DATA: txd = data[i] for i = 0..7, LSB first. The 3-bit index advances at each bit boundary and leaves DATA after i=7.
- PARITY: odd mode sends the bit that makes the total count of ones in data+parity odd, i.e. ~^data. Even mode sends ^data. Parity is computed from the latched byte.
- STOP: txd=1 for STOP_BITS*BAUD_DIV cycles.
- Completion: on the edge ending the last stop-bit cycle, the state returns to IDLE and done=1 for exactly that one cycle, with ready=1.
- Back-to-back frames: start=1 in the done cycle is accepted. This gives exactly one txd=1 idle cycle between frames, so the frame period is (10 + (PARITY!=0) + STOP_BITS-1)*BAUD_DIV + 1 cycles. At defaults that is 4341 cycles.
- Registering: txd is registered and glitch-free. No combinational path from start or data to txd.
- done is never asserted outside the IDLE-entry cycle. rst and done in the same cycle: rst wins and done=0.

Test Plan:
- Defaults, send 0x22 after reset release -> txd low for 434 cycles, then bits 0,1,0,0,0,1,0,0 at 434 cycles each, then high for 434 cycles. done pulses once, 4340 cycles after the first txd-low cycle. The uart_rx loopback reports data=0x22 with done.
- Back-to-back 0x11 then 0x33, with start held high -> one idle-high cycle between the frames; frame period 4341 cycles. The receiver yields 0x11 then 0x33 and two done pulses.
- start pulsed with data=0xFF 1000 cycles into a 0x34 frame -> the line carries 0x34 unchanged; exactly one done pulse; no second frame.
- PARITY=2, send 0x55 -> parity bit 0 (four ones). PARITY=1, send 0x55 -> parity bit 1. The frame is 11 bit times.
- STOP_BITS=2, send 0xA5 -> stop high for 868 cycles before done. A start issued earlier than the done cycle is ignored.
- rst asserted at the 3rd data bit of 0x0F -> txd=1 and ready=1 on the next cycle; no done pulse. A new 0x22 request right after rst deasserts transmits a correct full frame.
